// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, iterated LSB-first over WIDTH clocks.
// The operands are loaded on an accepted start. The parallel sum and carry-out are presented
// with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, breg_q, sreg_q;
  logic [CntW-1:0]  count_q;
  logic             carry_q;
  logic             fa_s, fa_c;
  logic             accept;
  logic             last;

  // The full-adder cell: the only arithmetic, reused for every bit position.
  assign fa_s = areg_q[0] ^ breg_q[0] ^ carry_q;
  assign fa_c = (areg_q[0] & breg_q[0]) | (carry_q & (areg_q[0] ^ breg_q[0]));

  // Start is only honoured outside SHIFT, so a running add cannot be disturbed.
  assign accept = start && (state_q != StShift);
  assign last   = (state_q == StShift) && (count_q == CntW'(WIDTH - 1));

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, serial shift datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg_q  <= '0;
      breg_q  <= '0;
      sreg_q  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      co      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      areg_q  <= a;
      breg_q  <= b;
      carry_q <= cin;
      count_q <= '0;
    end else if (state_q == StShift) begin
      carry_q <= fa_c;
      areg_q  <= areg_q >> 1;
      breg_q  <= breg_q >> 1;
      sreg_q  <= {fa_s, sreg_q[WIDTH-1:1]};
      count_q <= count_q + 1'b1;
      if (last) begin
        sum <= {fa_s, sreg_q[WIDTH-1:1]};
        co  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
        // On the last shift carry_q is the carry into the MSB.
        ovf <= carry_q ^ fa_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): the driver pushes the expected result and
// done cycle on each accepted start, and a negedge monitor pops and compares on every done.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, co;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] held_sum;
  logic         held_co;
  logic         held_ovf;
  logic         prev_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares results on done, and checks outputs are held in between.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_sum  = '0;
      held_co   = 1'b0;
      held_ovf  = 1'b0;
      prev_done = 1'b0;
    end else if (done) begin
      exp_t e;
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e.sum});
        chk("co", {31'd0, co}, {31'd0, e.co});
        chk("done_latency", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        held_sum = e.sum;
        held_co  = e.co;
        held_ovf = e.ovf;
      end
      prev_done = 1'b1;
    end else begin
      chk("sum_held", {24'd0, sum}, {24'd0, held_sum});
      chk("co_held", {31'd0, co}, {31'd0, held_co});
      prev_done = 1'b0;
    end
  end

  // Drive one start once the DUT can accept it; push the expected result and done cycle.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("accept_timeout", 32'd1, 32'd0);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.sum = es;
    e.co  = ec;
    e.ovf = eo;
    e.cyc = cyc + W;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int           nbusy;
    int           ndone;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   full;
    logic         rovf;

    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_co", {31'd0, co}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add with busy-length measurement.
    issue(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) nbusy++;
    end
    chk("busy_cycles", nbusy, W);
    drain();

    // Reset mid-SHIFT aborts: outputs clear at once and no done follows.
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_co", {31'd0, co}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // Carry boundaries.
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain();

    // Start and operand changes during SHIFT are ignored.
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: second start lands in DONE, done pulses 9 cycles apart.
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    drain();

    // Signed-overflow boundaries (sum/co checked in every build).
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain();

    // Random sweep against a+b+cin.
    for (int i = 0; i < 256; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      issue(ra, rb, rc, full[W-1:0], full[W], rovf);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
